inta_sequencer: RTL
===================

INTA_SEQUENCER -- requirements
Module: inta_sequencer

Interface
REQ-001 SHALL provide parameter PULSE_W, default 2, _INTA low time per acknowledge pulse in CLK cycles (legal range 1..15).
REQ-002 SHALL provide parameter GAP_W, default 2, _INTA high time between the two pulses in CLK cycles (legal range 1..15).
REQ-003 SHALL have port CLK input 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port _RST input 1, asynchronous active-low reset.
REQ-005 SHALL have port INT input 1, interrupt request from the PIC; asynchronous to CLK.
REQ-006 SHALL have port IF_EN input 1, CPU interrupt enable; high permits a new acknowledge sequence.
REQ-007 SHALL have port DATA_IN input 8, PIC data bus sampled during the second acknowledge pulse.
REQ-008 SHALL have port _INTA output 1, active-low interrupt acknowledge strobe to the PIC; registered.
REQ-009 SHALL have port VEC output 8, captured interrupt vector.
REQ-010 SHALL have port VEC_VALID output 1, high while VEC holds an unconsumed vector.
REQ-011 SHALL have port VEC_READY input 1, CPU-side accept for VEC.
REQ-012 SHALL have port BUSY output 1, high in any state other than IDLE.
REQ-013 SHALL have port ACK_CNT output 16, count of completed vector handshakes.

Function
REQ-014 SHALL synchronise INT through two CLK flops (int_s); the FSM uses only int_s.
REQ-015 SHALL implement FSM states IDLE, P1_LOW, GAP, P2_LOW and HOLD, with one shared down-counter for pulse and gap timing.
REQ-016 IDLE -> P1_LOW SHALL occur on the edge where int_s=1 and IF_EN=1; otherwise the FSM stays in IDLE.
REQ-017 _INTA SHALL be 0 for exactly PULSE_W cycles in P1_LOW, 1 for exactly GAP_W cycles in GAP, 0 for exactly PULSE_W cycles in P2_LOW, and 1 in every other state.
REQ-018 On the edge that ends P2_LOW, VEC SHALL load DATA_IN, VEC_VALID SHALL go 1, and the FSM SHALL enter HOLD.
REQ-019 DATA_IN during the first pulse SHALL be ignored.
REQ-020 Latency SHALL be fixed: from the first edge that samples INT=1 to VEC_VALID=1, the delay is 2+2*PULSE_W+GAP_W cycles (8 with defaults).
REQ-021 HOLD SHALL keep VEC and VEC_VALID stable until VEC_VALID=1 and VEC_READY=1 at an edge; that edge clears VEC_VALID, increments ACK_CNT, and returns the FSM to IDLE.
REQ-022 VEC SHALL retain its last value after the handshake.
REQ-023 VEC_READY SHALL be ignored in every state except HOLD.
REQ-024 A new sequence SHALL start no earlier than the cycle after the return to IDLE, and only if int_s=1 and IF_EN=1 at that time.
REQ-025 Once P1_LOW is entered, the sequence is atomic: deassertion of IF_EN or INT in P1_LOW, GAP or P2_LOW SHALL NOT shorten or abort it.
REQ-026 ACK_CNT SHALL saturate at 16'hFFFF and not wrap.
REQ-027 BUSY SHALL equal (state != IDLE), registered consistently with _INTA.

Reset
REQ-028 _RST=0 SHALL immediately, without waiting for CLK: force state IDLE, _INTA=1, VEC=8'h00, VEC_VALID=0, BUSY=0, ACK_CNT=0, both synchroniser flops 0 and the timing counter 0.
REQ-029 Reset asserted mid-pulse SHALL return _INTA to 1 at once, with no truncated-pulse recovery.
REQ-030 After _RST releases, the first sequence SHALL obey REQ-020 latency measured from INT sampling.

Verification
REQ-031 Defaults; INT=1, IF_EN=1, DATA_IN=8'h00 during pulse 1 and 8'hFF during pulse 2, VEC_READY=1 -> _INTA low 2, high 2, low 2; VEC=8'hFF; VEC_VALID high exactly 1 cycle, 8 cycles after INT sampled; ACK_CNT=1.
REQ-032 IF_EN=0 with INT=1 for 20 cycles -> _INTA stays 1 and BUSY stays 0; raise IF_EN -> sequence starts on the next edge.
REQ-033 VEC_READY=0 for 10 cycles after capture, DATA_IN=8'hF9 -> VEC=8'hF9 and VEC_VALID=1 stable throughout; ACK_CNT increments only on the VEC_READY=1 edge.
REQ-034 Drop IF_EN and INT during GAP -> both pulses complete with full widths, vector captured, FSM returns to IDLE, no second sequence.
REQ-035 Assert _RST=0 in the middle of P2_LOW -> _INTA=1, VEC_VALID=0, VEC=8'h00, ACK_CNT=0 before the next CLK edge.
REQ-036 PULSE_W=1, GAP_W=3, ACK_CNT preloaded by 65535 handshakes -> pulse timing 1/3/1, latency 7 cycles, ACK_CNT remains 16'hFFFF after the next handshake.

Source files
------------

// File: rtl/inta_sequencer.sv
// rtl/inta_sequencer.sv - two-pulse interrupt acknowledge sequencer with vector capture
module inta_sequencer #(
   parameter int PULSE_W = 2,
   parameter int GAP_W   = 2
) (
   input  logic        CLK,
   input  logic        _RST,
   input  logic        INT,
   input  logic        IF_EN,
   input  logic [7:0]  DATA_IN,
   output logic        _INTA,
   output logic [7:0]  VEC,
   output logic        VEC_VALID,
   input  logic        VEC_READY,
   output logic        BUSY,
   output logic [15:0] ACK_CNT
);

   typedef enum logic [2:0] {IDLE, P1_LOW, GAP, P2_LOW, HOLD} state_t;

   localparam logic [3:0] PULSE_LD = 4'(PULSE_W - 1);
   localparam logic [3:0] GAP_LD   = 4'(GAP_W - 1);

   state_t      state, state_nxt;
   logic [3:0]  cnt, cnt_nxt;
   logic        int_m, int_s;
   logic        inta_q, busy_q, vec_valid_q;
   logic [7:0]  vec_q;
   logic [15:0] ack_cnt_q;
   logic        capture, handshake;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      capture   = 1'b0;
      handshake = 1'b0;
      case (state)
         IDLE: begin
            if (int_s && IF_EN) begin
               state_nxt = P1_LOW;
               cnt_nxt   = PULSE_LD;
            end
         end
         P1_LOW: begin
            if (cnt == 4'd0) begin
               state_nxt = GAP;
               cnt_nxt   = GAP_LD;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         GAP: begin
            if (cnt == 4'd0) begin
               state_nxt = P2_LOW;
               cnt_nxt   = PULSE_LD;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         P2_LOW: begin
            if (cnt == 4'd0) begin
               state_nxt = HOLD;
               capture   = 1'b1;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         HOLD: begin
            // VEC_VALID is always high in HOLD, so READY alone completes the handshake
            if (VEC_READY) begin
               state_nxt = IDLE;
               handshake = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Strobe and busy are registered from the next state so they change with the state flop
   always_ff @(posedge CLK or negedge _RST) begin
      if (!_RST) begin
         int_m       <= 1'b0;
         int_s       <= 1'b0;
         state       <= IDLE;
         cnt         <= 4'd0;
         inta_q      <= 1'b1;
         busy_q      <= 1'b0;
         vec_q       <= 8'h00;
         vec_valid_q <= 1'b0;
         ack_cnt_q   <= 16'h0000;
      end else begin
         int_m  <= INT;
         int_s  <= int_m;
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         inta_q <= !((state_nxt == P1_LOW) || (state_nxt == P2_LOW));
         busy_q <= (state_nxt != IDLE);
         if (capture) begin
            vec_q       <= DATA_IN;
            vec_valid_q <= 1'b1;
         end
         if (handshake) begin
            vec_valid_q <= 1'b0;
            if (ack_cnt_q != 16'hFFFF) ack_cnt_q <= ack_cnt_q + 16'd1;
         end
      end
   end

   assign _INTA     = inta_q;
   assign BUSY      = busy_q;
   assign VEC       = vec_q;
   assign VEC_VALID = vec_valid_q;
   assign ACK_CNT   = ack_cnt_q;

endmodule
